// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and data-memory signals of the two-port data memory arbiter
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  _req0;
  logic                  _write0;
  logic                  _lock0;
  logic [DATA_WIDTH-1:0] _address0;
  logic [DATA_WIDTH-1:0] _valueIn0;
  logic                  grant0;
  logic                  readValid0;
  logic [DATA_WIDTH-1:0] readValue0;

  logic                  _req1;
  logic                  _write1;
  logic                  _lock1;
  logic [DATA_WIDTH-1:0] _address1;
  logic [DATA_WIDTH-1:0] _valueIn1;
  logic                  grant1;
  logic                  readValid1;
  logic [DATA_WIDTH-1:0] readValue1;

  logic                  memRead;
  logic                  memWrite;
  logic [DATA_WIDTH-1:0] memAddress;
  logic [DATA_WIDTH-1:0] memValueIn;
  logic [DATA_WIDTH-1:0] _memValueOut;

  modport slave (
    input  _req0, _write0, _lock0, _address0, _valueIn0,
    input  _req1, _write1, _lock1, _address1, _valueIn1,
    input  _memValueOut,
    output grant0, readValid0, readValue0,
    output grant1, readValid1, readValue1,
    output memRead, memWrite, memAddress, memValueIn
  );

  modport master (
    output _req0, _write0, _lock0, _address0, _valueIn0,
    output _req1, _write1, _lock1, _address1, _valueIn1,
    output _memValueOut,
    input  grant0, readValid0, readValue0,
    input  grant1, readValid1, readValue1,
    input  memRead, memWrite, memAddress, memValueIn
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin data memory arbiter with capped locked bursts
module dmem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic           _CLK,
  input  logic           _RESET,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [3:0] BURST_CAP = 4'(MAX_BURST);

  state_t                state;
  state_t                next_state;
  logic [3:0]            burst_count;
  logic [3:0]            next_count;
  logic                  last_grant;
  logic                  idle_g0;
  logic                  idle_g1;
  logic                  use_idle;
  logic                  arb_g0;
  logic                  arb_g1;
  logic                  g0;
  logic                  g1;
  logic                  rv0_q;
  logic                  rv1_q;
  logic [DATA_WIDTH-1:0] rvalue0_q;
  logic [DATA_WIDTH-1:0] rvalue1_q;

  // Plain round-robin pick: a lone requester wins, a tie goes to the port that did not win last
  always_comb begin
    idle_g0 = bus._req0 && (!bus._req1 || last_grant);
    idle_g1 = bus._req1 && (!bus._req0 || !last_grant);
  end

  // Next-state and grant decision; a locked owner keeps the memory until the cap lets the other port in
  always_comb begin
    arb_g0     = 1'b0;
    arb_g1     = 1'b0;
    next_state = IDLE;
    next_count = 4'd0;
    use_idle   = 1'b1;
    case (state)
      OWN0: begin
        if (bus._req0 && bus._lock0) begin
          use_idle = 1'b0;
          if ((burst_count < BURST_CAP) || !bus._req1) begin
            arb_g0     = 1'b1;
            next_state = OWN0;
            next_count = (burst_count == 4'hF) ? burst_count : burst_count + 4'd1;
          end else begin
            arb_g1     = 1'b1;
            next_state = bus._lock1 ? OWN1 : IDLE;
            next_count = bus._lock1 ? 4'd1 : 4'd0;
          end
        end
      end
      OWN1: begin
        if (bus._req1 && bus._lock1) begin
          use_idle = 1'b0;
          if ((burst_count < BURST_CAP) || !bus._req0) begin
            arb_g1     = 1'b1;
            next_state = OWN1;
            next_count = (burst_count == 4'hF) ? burst_count : burst_count + 4'd1;
          end else begin
            arb_g0     = 1'b1;
            next_state = bus._lock0 ? OWN0 : IDLE;
            next_count = bus._lock0 ? 4'd1 : 4'd0;
          end
        end
      end
      default: ;
    endcase
    if (use_idle) begin
      arb_g0 = idle_g0;
      arb_g1 = idle_g1;
      if (idle_g0 && bus._lock0) begin
        next_state = OWN0;
        next_count = 4'd1;
      end else if (idle_g1 && bus._lock1) begin
        next_state = OWN1;
        next_count = 4'd1;
      end
    end
  end

  // Grants are suppressed while reset is held so nothing reaches the memory
  always_comb begin
    g0 = arb_g0 && !_RESET;
    g1 = arb_g1 && !_RESET;
  end

  // Route the winner onto the memory lines; an idle bus is driven to zero
  always_comb begin
    bus.memRead    = 1'b0;
    bus.memWrite   = 1'b0;
    bus.memAddress = '0;
    bus.memValueIn = '0;
    if (g0) begin
      bus.memRead    = !bus._write0;
      bus.memWrite   = bus._write0;
      bus.memAddress = bus._address0;
      bus.memValueIn = bus._valueIn0;
    end else if (g1) begin
      bus.memRead    = !bus._write1;
      bus.memWrite   = bus._write1;
      bus.memAddress = bus._address1;
      bus.memValueIn = bus._valueIn1;
    end
  end

  // Arbitration state: ownership, burst length and the round-robin pointer
  always_ff @(posedge _CLK) begin
    if (_RESET) begin
      state       <= IDLE;
      burst_count <= 4'd0;
      last_grant  <= 1'b1;
    end else begin
      state       <= next_state;
      burst_count <= next_count;
      if (g0) begin
        last_grant <= 1'b0;
      end else if (g1) begin
        last_grant <= 1'b1;
      end
    end
  end

  // Capture read data at the end of the grant cycle and pulse the matching valid for one cycle
  always_ff @(posedge _CLK) begin
    if (_RESET) begin
      rv0_q     <= 1'b0;
      rv1_q     <= 1'b0;
      rvalue0_q <= '0;
      rvalue1_q <= '0;
    end else begin
      rv0_q <= g0 && !bus._write0;
      rv1_q <= g1 && !bus._write1;
      if (g0 && !bus._write0) begin
        rvalue0_q <= bus._memValueOut;
      end
      if (g1 && !bus._write1) begin
        rvalue1_q <= bus._memValueOut;
      end
    end
  end

  // A reset arriving while a response is in flight drops that response immediately
  always_comb begin
    bus.grant0     = g0;
    bus.grant1     = g1;
    bus.readValid0 = rv0_q && !_RESET;
    bus.readValid1 = rv1_q && !_RESET;
    bus.readValue0 = rvalue0_q;
    bus.readValue1 = rvalue1_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for the two-port data memory arbiter
module tb_dmem_arbiter;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] mem[256];
  logic [DW-1:0] exp_v0;
  logic [DW-1:0] exp_v1;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  dmem_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    ._CLK   (clk),
    ._RESET (rst),
    .bus    (bus)
  );

  function automatic logic [DW-1:0] init_val(input logic [DW-1:0] a);
    return a ^ 8'h4A;
  endfunction

  assign bus._memValueOut = mem[bus.memAddress];

  // Data memory model: preset contents, writes land on the clock edge
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_val(8'(i));
    forever begin
      @(posedge clk);
      if (bus.memWrite === 1'b1) mem[bus.memAddress] = bus.memValueIn;
    end
  end

  // Response monitor: every readValid pulse must match the oldest expected read for that port
  always @(negedge clk) begin
    if (bus.readValid0 === 1'b1) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL rsp0_unexpected: readValid0 with no outstanding read, value %0h", bus.readValue0);
      end else begin
        exp_v0 = q0.pop_front();
        if (bus.readValue0 !== exp_v0) begin
          errors++;
          $display("FAIL rsp0_data: got %0h expected %0h", bus.readValue0, exp_v0);
        end
      end
    end
    if (bus.readValid1 === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL rsp1_unexpected: readValid1 with no outstanding read, value %0h", bus.readValue1);
      end else begin
        exp_v1 = q1.pop_front();
        if (bus.readValue1 !== exp_v1) begin
          errors++;
          $display("FAIL rsp1_data: got %0h expected %0h", bus.readValue1, exp_v1);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus._req0 = 1'b0; bus._write0 = 1'b0; bus._lock0 = 1'b0; bus._address0 = '0; bus._valueIn0 = '0;
    bus._req1 = 1'b0; bus._write1 = 1'b0; bus._lock1 = 1'b0; bus._address1 = '0; bus._valueIn1 = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_reqs();
    for (int c = 0; c < 2; c++) begin
      if (c == 1) begin
        bus._req0 = 1'b1;
        bus._address0 = 8'h33;
      end
      @(negedge clk);
      checks++;
      if ({bus.grant0, bus.grant1, bus.memRead, bus.memWrite, bus.readValid0, bus.readValid1} !== 6'b0) begin
        errors++;
        $display("FAIL reset_ctrl: g0/g1/rd/wr/rv0/rv1 got %b expected 000000",
                 {bus.grant0, bus.grant1, bus.memRead, bus.memWrite, bus.readValid0, bus.readValid1});
      end
      checks++;
      if (bus.memAddress !== 8'h00 || bus.memValueIn !== 8'h00) begin
        errors++;
        $display("FAIL reset_bus: addr %0h data %0h expected 0 0", bus.memAddress, bus.memValueIn);
      end
      next_cycle();
    end
    rst = 1'b0;
    clear_reqs();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.grant0, bus.grant1, bus.memRead, bus.memWrite, bus.readValid0, bus.readValid1} !== 6'b0 ||
          bus.readValue0 !== 8'h00 || bus.readValue1 !== 8'h00) begin
        errors++;
        $display("FAIL idle_after_reset: ctrl %b rv0 %0h rv1 %0h expected 000000 0 0",
                 {bus.grant0, bus.grant1, bus.memRead, bus.memWrite, bus.readValid0, bus.readValid1},
                 bus.readValue0, bus.readValue1);
      end
      next_cycle();
    end
  endtask

  task automatic test_single_read();
    bus._req0 = 1'b1; bus._write0 = 1'b0; bus._lock0 = 1'b0; bus._address0 = 8'h10;
    @(negedge clk);
    checks++;
    if (bus.grant0 !== 1'b1 || bus.grant1 !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: g0 %b g1 %b expected 1 0", bus.grant0, bus.grant1);
    end
    checks++;
    if (bus.memRead !== 1'b1 || bus.memWrite !== 1'b0 || bus.memAddress !== 8'h10) begin
      errors++;
      $display("FAIL single_bus: rd %b wr %b addr %0h expected 1 0 10", bus.memRead, bus.memWrite, bus.memAddress);
    end
    q0.push_back(8'h5A);
    next_cycle();
    clear_reqs();
    @(negedge clk);
    checks++;
    if (bus.readValid0 !== 1'b1) begin
      errors++;
      $display("FAIL single_valid: readValid0 %b expected 1", bus.readValid0);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.readValid0 !== 1'b0 || bus.readValue0 !== 8'h5A) begin
      errors++;
      $display("FAIL single_hold: readValid0 %b readValue0 %0h expected 0 5a", bus.readValid0, bus.readValue0);
    end
    next_cycle();
  endtask

  task automatic test_burst_cap();
    logic [5:0]    exp1;
    logic [DW-1:0] a1;
    logic [DW-1:0] exp_addr;
    logic          p0_pending;
    int            k1;
    exp1 = 6'b10_1111;
    k1 = 0;
    p0_pending = 1'b1;
    for (int c = 0; c < 6; c++) begin
      a1 = 8'(8'h90 + k1);
      bus._req1 = 1'b1; bus._lock1 = 1'b1; bus._write1 = 1'b0; bus._address1 = a1;
      bus._req0 = p0_pending; bus._lock0 = 1'b0; bus._write0 = 1'b0; bus._address0 = 8'h50;
      @(negedge clk);
      checks++;
      if (bus.grant1 !== exp1[c] || bus.grant0 !== !exp1[c]) begin
        errors++;
        $display("FAIL burst_grant c%0d: g0 %b g1 %b expected %b %b", c, bus.grant0, bus.grant1, !exp1[c], exp1[c]);
      end
      exp_addr = exp1[c] ? a1 : 8'h50;
      checks++;
      if (bus.memAddress !== exp_addr || bus.memRead !== 1'b1) begin
        errors++;
        $display("FAIL burst_bus c%0d: addr %0h rd %b expected %0h 1", c, bus.memAddress, bus.memRead, exp_addr);
      end
      if (exp1[c]) begin
        q1.push_back(init_val(a1));
        k1++;
      end else begin
        q0.push_back(init_val(8'h50));
        p0_pending = 1'b0;
      end
      next_cycle();
    end
    clear_reqs();
    @(negedge clk);
    next_cycle();
  endtask

  task automatic test_contention();
    logic [DW-1:0] a0;
    logic [DW-1:0] a1;
    logic          exp_g0;
    logic          prev_g0;
    int            k0;
    int            k1;
    k0 = 0;
    k1 = 0;
    for (int c = 0; c < 6; c++) begin
      a0 = 8'(8'h40 + k0);
      a1 = 8'(8'h80 + k1);
      bus._req0 = 1'b1; bus._write0 = 1'b0; bus._lock0 = 1'b0; bus._address0 = a0;
      bus._req1 = 1'b1; bus._write1 = 1'b0; bus._lock1 = 1'b0; bus._address1 = a1;
      exp_g0 = (c % 2 == 0);
      @(negedge clk);
      checks++;
      if (bus.grant0 !== exp_g0 || bus.grant1 !== !exp_g0) begin
        errors++;
        $display("FAIL contend_grant c%0d: g0 %b g1 %b expected %b %b", c, bus.grant0, bus.grant1, exp_g0, !exp_g0);
      end
      if (c > 0) begin
        prev_g0 = ((c - 1) % 2 == 0);
        checks++;
        if (bus.readValid0 !== prev_g0 || bus.readValid1 !== !prev_g0) begin
          errors++;
          $display("FAIL contend_valid c%0d: rv0 %b rv1 %b expected %b %b", c, bus.readValid0, bus.readValid1, prev_g0, !prev_g0);
        end
      end
      if (exp_g0) begin
        q0.push_back(init_val(a0));
        k0++;
      end else begin
        q1.push_back(init_val(a1));
        k1++;
      end
      next_cycle();
    end
    clear_reqs();
    @(negedge clk);
    checks++;
    if (bus.readValid0 !== 1'b0 || bus.readValid1 !== 1'b1) begin
      errors++;
      $display("FAIL contend_tail: rv0 %b rv1 %b expected 0 1", bus.readValid0, bus.readValid1);
    end
    next_cycle();
  endtask

  task automatic test_write_then_read();
    bus._req0 = 1'b1; bus._write0 = 1'b1; bus._lock0 = 1'b0; bus._address0 = 8'h20; bus._valueIn0 = 8'hA5;
    @(negedge clk);
    checks++;
    if (bus.grant0 !== 1'b1 || bus.memWrite !== 1'b1 || bus.memRead !== 1'b0 ||
        bus.memAddress !== 8'h20 || bus.memValueIn !== 8'hA5) begin
      errors++;
      $display("FAIL wr_bus: g0 %b wr %b rd %b addr %0h data %0h expected 1 1 0 20 a5",
               bus.grant0, bus.memWrite, bus.memRead, bus.memAddress, bus.memValueIn);
    end
    next_cycle();
    clear_reqs();
    bus._req1 = 1'b1; bus._write1 = 1'b0; bus._address1 = 8'h20;
    @(negedge clk);
    checks++;
    if (bus.grant1 !== 1'b1 || bus.memRead !== 1'b1 || bus.memWrite !== 1'b0 || bus.readValid0 !== 1'b0) begin
      errors++;
      $display("FAIL rd_after_wr: g1 %b rd %b wr %b rv0 %b expected 1 1 0 0",
               bus.grant1, bus.memRead, bus.memWrite, bus.readValid0);
    end
    q1.push_back(8'hA5);
    next_cycle();
    clear_reqs();
    @(negedge clk);
    checks++;
    if (bus.readValid1 !== 1'b1 || bus.readValue1 !== 8'hA5) begin
      errors++;
      $display("FAIL wr_rd_value: rv1 %b value %0h expected 1 a5", bus.readValid1, bus.readValue1);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_burst();
    for (int c = 0; c < 2; c++) begin
      bus._req0 = 1'b1; bus._lock0 = 1'b1; bus._write0 = 1'b0; bus._address0 = 8'(8'h60 + c);
      @(negedge clk);
      checks++;
      if (bus.grant0 !== 1'b1) begin
        errors++;
        $display("FAIL lock_grant c%0d: g0 %b expected 1", c, bus.grant0);
      end
      q0.push_back(init_val(8'(8'h60 + c)));
      next_cycle();
    end
    rst = 1'b1;
    bus._address0 = 8'h62;
    @(negedge clk);
    checks++;
    if (bus.grant0 !== 1'b0 || bus.readValid0 !== 1'b0 || bus.memRead !== 1'b0) begin
      errors++;
      $display("FAIL midreset_out: g0 %b rv0 %b rd %b expected 0 0 0", bus.grant0, bus.readValid0, bus.memRead);
    end
    q0.delete();
    next_cycle();
    rst = 1'b0;
    bus._req1 = 1'b1; bus._lock1 = 1'b0; bus._write1 = 1'b0; bus._address1 = 8'hA0;
    @(negedge clk);
    checks++;
    if (bus.grant0 !== 1'b1 || bus.grant1 !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_tie: g0 %b g1 %b expected 1 0", bus.grant0, bus.grant1);
    end
    checks++;
    if (bus.readValid0 !== 1'b0 || bus.readValue0 !== 8'h00) begin
      errors++;
      $display("FAIL post_reset_rsp: rv0 %b value %0h expected 0 0", bus.readValid0, bus.readValue0);
    end
    q0.push_back(init_val(8'h62));
    next_cycle();
    bus._req0 = 1'b0; bus._lock0 = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.grant1 !== 1'b1 || bus.readValid0 !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_handover: g1 %b rv0 %b expected 1 1", bus.grant1, bus.readValid0);
    end
    q1.push_back(init_val(8'hA0));
    next_cycle();
    clear_reqs();
    @(negedge clk);
    next_cycle();
  endtask

  initial begin
    clear_reqs();
    rst = 1'b1;
    test_reset();
    test_single_read();
    test_burst_cap();
    test_contention();
    test_write_then_read();
    test_reset_mid_burst();
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL missing_rsp: outstanding reads p0 %0d p1 %0d expected 0 0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single data memory between two requesters: port 0 (core load/store stage) and port 1 (loader/debug engine). Each cycle it picks at most one request, drives the memory's read/write/address/value lines, and returns registered read data to the winning port. Round-robin fairness, optional locked bursts with a starvation cap. Sits between the execute/memory stage plus loader and the data memory.

Parameters:
DATA_WIDTH, 8, address and data width; equals the package DATA_WIDTH
MAX_BURST, 4, max consecutive locked grants to one port while the other waits; range 1..15

Ports:
_CLK  input  1  clock; all state updates on posedge
_RESET  input  1  synchronous, active-high reset
_req0  input  1  port 0 request; held until granted
_write0  input  1  port 0: 1 = write, 0 = read
_lock0  input  1  port 0 asks to keep ownership for following requests
_address0  input  DATA_WIDTH  port 0 address
_valueIn0  input  DATA_WIDTH  port 0 write data
grant0  output  1  port 0 request accepted this cycle
readValid0  output  1  readValue0 valid (one cycle)
readValue0  output  DATA_WIDTH  port 0 read data
_req1, _write1, _lock1, _address1, _valueIn1  input  as port 0  port 1 request side
grant1, readValid1, readValue1  output  as port 0  port 1 response side
memRead  output  1  data memory read enable
memWrite  output  1  data memory write enable
memAddress  output  DATA_WIDTH  data memory address
memValueIn  output  DATA_WIDTH  data memory write data
_memValueOut  input  DATA_WIDTH  data memory combinational read data

Behaviour:
- Reset (_RESET high at posedge): state IDLE, lastGrant=1 (port 0 wins first tie), burstCount=0, readValid0/1=0, readValue0/1=0. While _RESET is high, grant0/1, memRead, memWrite are forced 0; memAddress, memValueIn are 0.
- Transfer: occurs in a cycle where reqN && grantN. Grant is combinational from current requests and registered state; at most one grant per cycle; no grant without request.
- Memory drive: winner's address/value routed; memWrite = winner && write; memRead = winner && !write. No winner: memRead=memWrite=0, memAddress=memValueIn=0.
- Write latency: committed at the posedge ending the grant cycle. No response pulse.
- Read latency 1: at the posedge ending the grant cycle, _memValueOut is captured into readValueN and readValidN=1 for exactly the next cycle. readValueN holds its last value afterwards. Back-to-back reads give back-to-back readValid.
- Requester keeps req/write/lock/address/valueIn stable until grant; a request dropped before grant is discarded without effect.
- FSM states: IDLE, OWN0, OWN1.
  IDLE: one requester -> it wins. Both -> port != lastGrant wins. If the winner's lock is high: go to OWNn, burstCount=1. Otherwise stay IDLE.
  OWNn, owner requesting with lock high: owner wins if burstCount < MAX_BURST or other port idle; burstCount increments, saturating at 15.
  OWNn, burstCount >= MAX_BURST and other port requesting: other port wins this cycle; next state OWNother (count=1) if its lock is high, else IDLE.
  OWNn, owner req or lock low: arbitrate as IDLE in the same cycle (no bubble); next state per IDLE rules.
- lastGrant updates to the winner on every transfer.
- Address/data arithmetic: pass-through only, no wrap logic. Addresses 0..2**DATA_WIDTH-1 are all legal.
- Reset mid-burst: FSM returns to IDLE. A read granted in the cycle reset rises produces no readValid. An in-flight readValid is cleared.
- Same-cycle write and read to the same address from different ports cannot occur (single grant). Port 0 write then port 1 read on the next cycle returns the new value.

Test Plan:
- Reset then idle: _RESET high 2 cycles -> all grants, readValid, memRead, memWrite 0; after release with no requests, outputs stay 0.
- Single read: port 0 reads addr 0x10, memory holds 0x5A -> grant0 same cycle, memRead=1, memAddress=0x10; next cycle readValid0=1, readValue0=0x5A; following cycle readValid0=0.
- Contention, no lock: both ports request continuously, all reads -> grants alternate 0,1,0,1; each readValid pulses one cycle after that port's grant.
- Locked burst cap (MAX_BURST=4): port 1 locked requesting 6 cycles, port 0 requesting from cycle 0 -> grant1 for 4 cycles, then grant0, then grant1.
- Write-then-read: port 0 writes 0xA5 to 0x20, next cycle port 1 reads 0x20 -> memWrite pulse with memValueIn=0xA5; readValue1=0xA5 one cycle after grant1.
- Reset mid-burst: port 0 locked at burstCount=2, assert _RESET one cycle -> grant0=0 and readValid0=0 during reset; afterwards state IDLE, port 0 wins a tie.
